// File: rtl/spi_load_master.sv
// SPI master for the PULPino SPI-slave load protocol: command 0x02, 32-bit address, then 32-bit words.
// Define SPI_LOAD_MASTER_QPI_EN to build quad-lane support (QEN/GAP states, qpi_on flag, sdo[3:1]).
module spi_load_master #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned NW_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [31:0]         addr_i,
  input  logic [NW_WIDTH-1:0] nwords_i,
  input  logic                qpi_i,
  input  logic [31:0]         wdata_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                spi_sck_o,
  output logic                spi_csn_o,
  output logic [3:0]          spi_sdo_o
);

  typedef enum logic [3:0] {IDLE, QEN, GAP, CMD, ADDR, DATA, WAIT, END, DONE} state_e;

  localparam logic [9:0]  HALF_LAST = 10'(CLK_DIV - 1);
  localparam logic [9:0]  GAP_LAST  = 10'(4 * CLK_DIV - 1);
  localparam logic [31:0] CMD_WORD  = 32'h0200_0000;
  localparam logic [31:0] QEN_WORD  = 32'h0101_0000;

  state_e              state_q, state_d;
  logic [9:0]          tmr_q, tmr_d;
  logic                sck_q, sck_d;
  logic                tail_q, tail_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [31:0]         sh_q, sh_d;
  logic [31:0]         addr_q, addr_d;
  logic [NW_WIDTH-1:0] words_q, words_d;
  logic                quad;
  logic                load_word;
  logic                selected;
  logic [4:0]          cmd_last;
  logic [4:0]          word_last;

`ifdef SPI_LOAD_MASTER_QPI_EN
  logic qpi_on_q, qpi_on_d;
  assign quad = qpi_on_q && (state_q != QEN);
`else
  logic unused_qpi;
  assign unused_qpi = qpi_i;
  assign quad       = 1'b0;
`endif

  assign cmd_last  = quad ? 5'd1 : 5'd7;
  assign word_last = quad ? 5'd7 : 5'd31;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    sck_d     = sck_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    words_d   = words_q;
    load_word = 1'b0;
`ifdef SPI_LOAD_MASTER_QPI_EN
    qpi_on_d  = qpi_on_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = addr_i;
          words_d = nwords_i;
          tmr_d   = '0;
          sck_d   = 1'b0;
          tail_d  = 1'b0;
`ifdef SPI_LOAD_MASTER_QPI_EN
          if (qpi_i && !qpi_on_q) begin
            state_d = QEN;
            sh_d    = QEN_WORD;
            cnt_d   = 5'd15;
          end else
`endif
          begin
            state_d = CMD;
            sh_d    = CMD_WORD;
            cnt_d   = cmd_last;
          end
        end
      end
      QEN, CMD, ADDR, DATA: begin
        tmr_d = tmr_q + 10'd1;
        if (tmr_q == HALF_LAST) begin
          tmr_d = '0;
          if (!sck_q) begin
            // tail_q marks the extra low half after the final falling edge, with CSN still low
            if (tail_q) begin
              tail_d = 1'b0;
              if (state_q == QEN) begin
                state_d = GAP;
`ifdef SPI_LOAD_MASTER_QPI_EN
                qpi_on_d = 1'b1;
`endif
              end else begin
                state_d = END;
              end
            end else begin
              sck_d = 1'b1;
            end
          end else begin
            sck_d = 1'b0;
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 5'd1;
              sh_d  = quad ? {sh_q[27:0], 4'b0000} : {sh_q[30:0], 1'b0};
            end else if (state_q == QEN) begin
              tail_d = 1'b1;
            end else if (state_q == CMD) begin
              state_d = ADDR;
              sh_d    = addr_q;
              cnt_d   = word_last;
            end else if (words_q == '0) begin
              tail_d = 1'b1;
            end else if (wvalid_i) begin
              load_word = 1'b1;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        tmr_d     = '0;
        sck_d     = 1'b0;
        load_word = wvalid_i;
      end
`ifdef SPI_LOAD_MASTER_QPI_EN
      GAP: begin
        tmr_d = tmr_q + 10'd1;
        if (tmr_q == GAP_LAST) begin
          tmr_d   = '0;
          state_d = CMD;
          sh_d    = CMD_WORD;
          cnt_d   = cmd_last;
        end
      end
`endif
      END:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load_word) begin
      state_d = DATA;
      sh_d    = wdata_i;
      cnt_d   = word_last;
      words_d = words_q - NW_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      sck_q    <= 1'b0;
      tail_q   <= 1'b0;
      cnt_q    <= '0;
      sh_q     <= '0;
      addr_q   <= '0;
      words_q  <= '0;
`ifdef SPI_LOAD_MASTER_QPI_EN
      qpi_on_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      sck_q    <= sck_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      addr_q   <= addr_d;
      words_q  <= words_d;
`ifdef SPI_LOAD_MASTER_QPI_EN
      qpi_on_q <= qpi_on_d;
`endif
    end
  end

  assign selected  = (state_q == QEN) || (state_q == CMD) || (state_q == ADDR) ||
                     (state_q == DATA) || (state_q == WAIT);
  assign wready_o  = load_word;
  assign busy_o    = (state_q != IDLE) && (state_q != DONE);
  assign done_o    = (state_q == DONE);
  assign spi_sck_o = sck_q;
  assign spi_csn_o = !selected;

  always_comb begin
    spi_sdo_o = '0;
    if (selected) begin
      if (quad) spi_sdo_o = sh_q[31:28];
      else      spi_sdo_o[0] = sh_q[31];
    end
  end

endmodule

// File: tb/tb_spi_load_master.sv
// Directed bench for spi_load_master: captures lanes on SCK rising edges and decodes frames like the slave.
module tb_spi_load_master;
  localparam int unsigned CLK_DIV = 2;
`ifdef SPI_LOAD_MASTER_QPI_EN
  localparam bit QPI = 1'b1;
`else
  localparam bit QPI = 1'b0;
`endif
  localparam int CL = QPI ? 2 : 8;
  localparam int WL = QPI ? 8 : 32;

  logic        clk = 1'b0, rst = 1'b1, start_i = 1'b0, qpi_i = 1'b0, wvalid_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [15:0] nwords_i = '0;
  logic        wready_o, busy_o, done_o, spi_sck_o, spi_csn_o;
  logic [3:0]  spi_sdo_o;

  int cmp = 0, fail = 0;
  logic [3:0]  edges[$];
  int          frame_len[$];
  int          cur_len = 0;
  logic [31:0] wq[4];

  int   r_tout, r_done, r_wready, r_csn_low, r_bch, r_viol, r_eb, r_fb;
  logic r_first_csn, r_done_busy;

  spi_load_master #(.CLK_DIV(CLK_DIV), .NW_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .addr_i(addr_i), .nwords_i(nwords_i),
    .qpi_i(qpi_i), .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .busy_o(busy_o), .done_o(done_o), .spi_sck_o(spi_sck_o), .spi_csn_o(spi_csn_o),
    .spi_sdo_o(spi_sdo_o)
  );

  always #5 clk = ~clk;

  // Slave-side capture: lanes on each SCK rise while selected; frame length logged when CSN rises.
  always @(posedge spi_sck_o or posedge spi_csn_o) begin
    if (spi_csn_o) begin
      frame_len.push_back(cur_len);
      cur_len = 0;
    end else begin
      edges.push_back(spi_sdo_o);
      cur_len++;
    end
  end

  function automatic logic [31:0] dec(input int b, input int nbits, input bit qd);
    logic [31:0] v;
    v = '0;
    if (qd) for (int i = 0; i < nbits / 4; i++) v = {v[27:0], edges[b + i]};
    else    for (int i = 0; i < nbits; i++)     v = {v[30:0], edges[b + i][0]};
    return v;
  endfunction

  function automatic int hi_lanes(input int b, input int cnt);
    int n;
    n = 0;
    for (int i = 0; i < cnt; i++) if (edges[b + i][3:1] !== 3'b000) n++;
    return n;
  endfunction

  task automatic run_xfer(input logic [31:0] addr, input int n, input logic qpi,
                          input int stall_word, input int poke_cycle);
    int   idx, stall_left, post;
    logic adv;
    idx = 0; stall_left = 0; post = 0; adv = 1'b0;
    r_tout = 1; r_done = 0; r_wready = 0; r_csn_low = 0; r_bch = 0; r_viol = 0;
    r_first_csn = 1'bx; r_done_busy = 1'b0;
    r_eb = edges.size(); r_fb = frame_len.size();
    @(negedge clk);
    start_i = 1'b1; addr_i = addr; nwords_i = 16'(n); qpi_i = qpi;
    wdata_i = wq[0]; wvalid_i = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      start_i = (cyc == poke_cycle);
      if (adv) begin
        idx++;
        if (idx < 4) wdata_i = wq[idx];
        if (idx == stall_word) stall_left = 138;
      end
      wvalid_i = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      if (cyc == 0) r_first_csn = spi_csn_o;
      if (!wvalid_i && stall_left < 8 && (spi_sck_o || spi_csn_o)) r_viol++;
      adv = wready_o;
      if (wready_o) r_wready++;
      if (!spi_csn_o) r_csn_low++;
      if (busy_o && spi_csn_o) r_bch++;
      if (done_o) begin
        r_done++;
        if (busy_o) r_done_busy = 1'b1;
      end
      if (r_done > 0) post++;
      if (post == 6) begin
        r_tout = 0;
        break;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    cmp++; if (spi_sck_o !== 1'b0) begin fail++; $display("FAIL rst_sck: got %b want 0", spi_sck_o); end
    cmp++; if (spi_csn_o !== 1'b1) begin fail++; $display("FAIL rst_csn: got %b want 1", spi_csn_o); end
    cmp++; if (spi_sdo_o !== 4'h0) begin fail++; $display("FAIL rst_sdo: got %h want 0", spi_sdo_o); end
    cmp++; if (busy_o !== 1'b0) begin fail++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    cmp++; if (done_o !== 1'b0) begin fail++; $display("FAIL rst_done: got %b want 0", done_o); end
    cmp++; if (wready_o !== 1'b0) begin fail++; $display("FAIL rst_wready: got %b want 0", wready_o); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    wq[0] = 32'hDEAD_BEEF;
    run_xfer(32'h0000_0000, 1, 1'b0, -1, -1);
    cmp++; if (r_tout !== 0) begin fail++; $display("FAIL single_timeout: got %0d want 0", r_tout); end
    cmp++; if (r_first_csn !== 1'b0) begin fail++; $display("FAIL single_csn_fall: got %b want 0", r_first_csn); end
    cmp++; if (r_done !== 1) begin fail++; $display("FAIL single_done: got %0d want 1", r_done); end
    cmp++; if (r_done_busy !== 1'b0) begin fail++; $display("FAIL single_busy_at_done: got %b want 0", r_done_busy); end
    cmp++; if (r_wready !== 1) begin fail++; $display("FAIL single_wready: got %0d want 1", r_wready); end
    cmp++; if (r_csn_low !== 290) begin fail++; $display("FAIL single_csn_low: got %0d want 290", r_csn_low); end
    cmp++; if (r_bch !== 1) begin fail++; $display("FAIL single_csn_hi_busy: got %0d want 1", r_bch); end
    cmp++; if (frame_len.size() - r_fb !== 1) begin fail++; $display("FAIL single_frames: got %0d want 1", frame_len.size() - r_fb); end
    cmp++; if (frame_len[r_fb] !== 72) begin fail++; $display("FAIL single_sck: got %0d want 72", frame_len[r_fb]); end
    cmp++; if (dec(r_eb, 8, 1'b0) !== 32'h02) begin fail++; $display("FAIL single_cmd: got %h want 02", dec(r_eb, 8, 1'b0)); end
    cmp++; if (dec(r_eb + 8, 32, 1'b0) !== 32'h0) begin fail++; $display("FAIL single_addr: got %h want 0", dec(r_eb + 8, 32, 1'b0)); end
    cmp++; if (dec(r_eb + 40, 32, 1'b0) !== 32'hDEAD_BEEF) begin fail++; $display("FAIL single_data: got %h want deadbeef", dec(r_eb + 40, 32, 1'b0)); end
    cmp++; if (hi_lanes(r_eb, 72) !== 0) begin fail++; $display("FAIL single_hi_lanes: got %0d want 0", hi_lanes(r_eb, 72)); end
  endtask

  task automatic test_zero_words;
    run_xfer(32'h1A10_7008, 0, 1'b0, -1, -1);
    cmp++; if (r_tout !== 0) begin fail++; $display("FAIL zero_timeout: got %0d want 0", r_tout); end
    cmp++; if (frame_len[r_fb] !== 40) begin fail++; $display("FAIL zero_sck: got %0d want 40", frame_len[r_fb]); end
    cmp++; if (r_wready !== 0) begin fail++; $display("FAIL zero_wready: got %0d want 0", r_wready); end
    cmp++; if (r_done !== 1) begin fail++; $display("FAIL zero_done: got %0d want 1", r_done); end
    cmp++; if (r_csn_low !== 162) begin fail++; $display("FAIL zero_csn_low: got %0d want 162", r_csn_low); end
    cmp++; if (dec(r_eb, 8, 1'b0) !== 32'h02) begin fail++; $display("FAIL zero_cmd: got %h want 02", dec(r_eb, 8, 1'b0)); end
    cmp++; if (dec(r_eb + 8, 32, 1'b0) !== 32'h1A10_7008) begin fail++; $display("FAIL zero_addr: got %h want 1a107008", dec(r_eb + 8, 32, 1'b0)); end
  endtask

  task automatic test_stall;
    wq[0] = 32'h0123_4567; wq[1] = 32'h89AB_CDEF; wq[2] = 32'h0F1E_2D3C;
    run_xfer(32'h0000_1000, 3, 1'b0, 1, -1);
    cmp++; if (r_tout !== 0) begin fail++; $display("FAIL stall_timeout: got %0d want 0", r_tout); end
    cmp++; if (frame_len[r_fb] !== 136) begin fail++; $display("FAIL stall_sck: got %0d want 136", frame_len[r_fb]); end
    cmp++; if (r_viol !== 0) begin fail++; $display("FAIL stall_lines: got %0d bad cycles want 0", r_viol); end
    cmp++; if (r_csn_low < 550 || r_csn_low > 565) begin fail++; $display("FAIL stall_csn_low: got %0d want 550..565", r_csn_low); end
    cmp++; if (r_wready !== 3) begin fail++; $display("FAIL stall_wready: got %0d want 3", r_wready); end
    cmp++; if (r_done !== 1) begin fail++; $display("FAIL stall_done: got %0d want 1", r_done); end
    cmp++; if (dec(r_eb + 40, 32, 1'b0) !== 32'h0123_4567) begin fail++; $display("FAIL stall_w0: got %h want 01234567", dec(r_eb + 40, 32, 1'b0)); end
    cmp++; if (dec(r_eb + 72, 32, 1'b0) !== 32'h89AB_CDEF) begin fail++; $display("FAIL stall_w1: got %h want 89abcdef", dec(r_eb + 72, 32, 1'b0)); end
    cmp++; if (dec(r_eb + 104, 32, 1'b0) !== 32'h0F1E_2D3C) begin fail++; $display("FAIL stall_w2: got %h want 0f1e2d3c", dec(r_eb + 104, 32, 1'b0)); end
  endtask

  task automatic test_quad;
    int e;
    wq[0] = 32'h1122_3344; wq[1] = 32'hA5A5_5A5A;
    run_xfer(32'h0000_8000, 2, 1'b1, -1, -1);
    e = r_eb + (QPI ? 16 : 0);
    cmp++; if (r_tout !== 0) begin fail++; $display("FAIL quad_timeout: got %0d want 0", r_tout); end
    cmp++; if (frame_len.size() - r_fb !== (QPI ? 2 : 1)) begin fail++; $display("FAIL quad_frames: got %0d want %0d", frame_len.size() - r_fb, QPI ? 2 : 1); end
    cmp++; if (dec(r_eb, 16, 1'b0) !== (QPI ? 32'h0101 : 32'h0200)) begin fail++; $display("FAIL quad_first16: got %h want %h", dec(r_eb, 16, 1'b0), QPI ? 32'h0101 : 32'h0200); end
    cmp++; if (hi_lanes(r_eb, 16) !== 0) begin fail++; $display("FAIL quad_qen_lanes: got %0d want 0", hi_lanes(r_eb, 16)); end
    cmp++; if (frame_len[r_fb + (QPI ? 1 : 0)] !== (QPI ? 26 : 104)) begin fail++; $display("FAIL quad_sck: got %0d want %0d", frame_len[r_fb + (QPI ? 1 : 0)], QPI ? 26 : 104); end
    cmp++; if (r_bch !== (QPI ? 9 : 1)) begin fail++; $display("FAIL quad_gap: got %0d want %0d", r_bch, QPI ? 9 : 1); end
    cmp++; if (r_csn_low !== (QPI ? 172 : 418)) begin fail++; $display("FAIL quad_csn_low: got %0d want %0d", r_csn_low, QPI ? 172 : 418); end
    cmp++; if (dec(e, 8, QPI) !== 32'h02) begin fail++; $display("FAIL quad_cmd: got %h want 02", dec(e, 8, QPI)); end
    cmp++; if (dec(e + CL, 32, QPI) !== 32'h0000_8000) begin fail++; $display("FAIL quad_addr: got %h want 00008000", dec(e + CL, 32, QPI)); end
    cmp++; if (dec(e + CL + WL, 32, QPI) !== 32'h1122_3344) begin fail++; $display("FAIL quad_w0: got %h want 11223344", dec(e + CL + WL, 32, QPI)); end
    cmp++; if (dec(e + CL + 2 * WL, 32, QPI) !== 32'hA5A5_5A5A) begin fail++; $display("FAIL quad_w1: got %h want a5a55a5a", dec(e + CL + 2 * WL, 32, QPI)); end
    wq[0] = 32'hCAFE_F00D;
    run_xfer(32'h0000_0100, 1, 1'b0, -1, -1);
    cmp++; if (frame_len.size() - r_fb !== 1) begin fail++; $display("FAIL quad2_frames: got %0d want 1", frame_len.size() - r_fb); end
    cmp++; if (frame_len[r_fb] !== (QPI ? 18 : 72)) begin fail++; $display("FAIL quad2_sck: got %0d want %0d", frame_len[r_fb], QPI ? 18 : 72); end
    cmp++; if (r_csn_low !== (QPI ? 74 : 290)) begin fail++; $display("FAIL quad2_csn_low: got %0d want %0d", r_csn_low, QPI ? 74 : 290); end
    cmp++; if (dec(r_eb, 8, QPI) !== 32'h02) begin fail++; $display("FAIL quad2_cmd: got %h want 02", dec(r_eb, 8, QPI)); end
    cmp++; if (dec(r_eb + CL, 32, QPI) !== 32'h0000_0100) begin fail++; $display("FAIL quad2_addr: got %h want 00000100", dec(r_eb + CL, 32, QPI)); end
    cmp++; if (dec(r_eb + CL + WL, 32, QPI) !== 32'hCAFE_F00D) begin fail++; $display("FAIL quad2_data: got %h want cafef00d", dec(r_eb + CL + WL, 32, QPI)); end
  endtask

  task automatic test_abort;
    int nd;
    @(negedge clk);
    start_i = 1'b1; qpi_i = 1'b1; addr_i = 32'h55AA_0000; nwords_i = 16'd1;
    wdata_i = 32'h1357_9BDF; wvalid_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat ((QPI ? 24 : 60) - 1) @(negedge clk);
    #1;
    cmp++; if (spi_csn_o !== 1'b0) begin fail++; $display("FAIL abort_pre_csn: got %b want 0", spi_csn_o); end
    rst = 1'b1;
    @(negedge clk);
    #1;
    cmp++; if (spi_csn_o !== 1'b1) begin fail++; $display("FAIL abort_csn: got %b want 1", spi_csn_o); end
    cmp++; if (spi_sck_o !== 1'b0) begin fail++; $display("FAIL abort_sck: got %b want 0", spi_sck_o); end
    cmp++; if (busy_o !== 1'b0) begin fail++; $display("FAIL abort_busy: got %b want 0", busy_o); end
    cmp++; if (spi_sdo_o !== 4'h0) begin fail++; $display("FAIL abort_sdo: got %h want 0", spi_sdo_o); end
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (done_o) nd++;
    end
    cmp++; if (nd !== 0) begin fail++; $display("FAIL abort_done: got %0d want 0", nd); end
    wq[0] = 32'h600D_F00D;
    run_xfer(32'h0000_0020, 1, 1'b1, -1, -1);
    cmp++; if (r_tout !== 0) begin fail++; $display("FAIL requen_timeout: got %0d want 0", r_tout); end
    cmp++; if (frame_len.size() - r_fb !== (QPI ? 2 : 1)) begin fail++; $display("FAIL requen_frames: got %0d want %0d", frame_len.size() - r_fb, QPI ? 2 : 1); end
    cmp++; if (dec(r_eb, 16, 1'b0) !== (QPI ? 32'h0101 : 32'h0200)) begin fail++; $display("FAIL requen_first16: got %h want %h", dec(r_eb, 16, 1'b0), QPI ? 32'h0101 : 32'h0200); end
    cmp++; if (r_bch !== (QPI ? 9 : 1)) begin fail++; $display("FAIL requen_gap: got %0d want %0d", r_bch, QPI ? 9 : 1); end
    cmp++; if (dec(r_eb + (QPI ? 16 : 0) + CL + WL, 32, QPI) !== 32'h600D_F00D) begin fail++; $display("FAIL requen_data: got %h want 600df00d", dec(r_eb + (QPI ? 16 : 0) + CL + WL, 32, QPI)); end
  endtask

  task automatic test_busy_start;
    wq[0] = 32'h1234_5678;
    run_xfer(32'h0000_0040, 1, 1'b0, -1, 30);
    cmp++; if (r_tout !== 0) begin fail++; $display("FAIL busystart_timeout: got %0d want 0", r_tout); end
    cmp++; if (r_done !== 1) begin fail++; $display("FAIL busystart_done: got %0d want 1", r_done); end
    cmp++; if (frame_len.size() - r_fb !== 1) begin fail++; $display("FAIL busystart_frames: got %0d want 1", frame_len.size() - r_fb); end
    cmp++; if (frame_len[r_fb] !== (QPI ? 18 : 72)) begin fail++; $display("FAIL busystart_sck: got %0d want %0d", frame_len[r_fb], QPI ? 18 : 72); end
    cmp++; if (dec(r_eb + CL + WL, 32, QPI) !== 32'h1234_5678) begin fail++; $display("FAIL busystart_data: got %h want 12345678", dec(r_eb + CL + WL, 32, QPI)); end
    cmp++; if (busy_o !== 1'b0) begin fail++; $display("FAIL busystart_idle: got %b want 0", busy_o); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_zero_words;
    test_stall;
    test_quad;
    test_abort;
    test_busy_start;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
    $finish;
  end

endmodule
